// File: rtl/mac_requant_pack.sv
// Requantizes signed 32-bit MAC results to int8 (scale, round-shift, zero point,
// optional ReLU, saturate) and packs LANES results per AXI-Stream output beat.
module mac_requant_pack #(
   parameter int SCALE_W = 16,
   parameter int SHIFT_W = 5,
   parameter int LANES   = 4
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   input  logic [31:0]          SD_AXIS_TDATA,
   input  logic                 SD_AXIS_TVALID,
   input  logic                 SD_AXIS_TLAST,
   output logic                 SD_AXIS_TREADY,
   output logic [8*LANES-1:0]   MO_AXIS_TDATA,
   output logic [LANES-1:0]     MO_AXIS_TKEEP,
   output logic                 MO_AXIS_TVALID,
   output logic                 MO_AXIS_TLAST,
   input  logic                 MO_AXIS_TREADY,
   input  logic [SCALE_W-1:0]   cfg_scale,
   input  logic [SHIFT_W-1:0]   cfg_shift,
   input  logic [7:0]           cfg_zero_point,
   input  logic                 cfg_relu
);

   localparam int DW    = 8 * LANES;
   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PW    = 32 + SCALE_W + 1;
   localparam int RW    = PW + 1;

   localparam logic signed [RW-1:0] SAT_HI = RW'(127);
   localparam logic signed [RW-1:0] SAT_LO = -RW'(128);

   // Handshake: a beat moves on either port only in a cycle where VALID && READY
   // at the rising edge; a raised VALID and its payload are never withdrawn or
   // altered until that transfer happens. READY may depend on the downstream READY.

   logic                 rdy_en;
   logic                 a_valid, a_last;
   logic signed [PW-1:0] a_prod;
   logic                 b_valid, b_last;
   logic signed [RW-1:0] b_r;
   logic                 c_valid, c_last;
   logic [7:0]           c_q;
   logic [CNT_W-1:0]     cnt;
   logic [DW-1:0]        pack_data;
   logic [LANES-1:0]     pack_keep;
   logic                 o_valid, o_last;
   logic [DW-1:0]        o_data;
   logic [LANES-1:0]     o_keep;

   logic signed [PW-1:0] mul_a, mul_b, mul_p;
   logic signed [RW-1:0] rnd, req_r;
   logic signed [RW-1:0] zp_w, q_w;
   logic [7:0]           sat_q;
   logic                 c_close, out_free, freeze, advance, accept;
   logic [DW-1:0]        merged_data;
   logic [LANES-1:0]     merged_keep;

   always_comb begin
      mul_a = $signed({{(PW-32){SD_AXIS_TDATA[31]}}, SD_AXIS_TDATA});
      mul_b = $signed({{(PW-SCALE_W){1'b0}}, cfg_scale});
      mul_p = mul_a * mul_b;
   end

   // Round half up: add half an LSB of the result before the arithmetic shift.
   always_comb begin
      rnd   = '0;
      if (cfg_shift != '0)
         rnd = $signed(RW'(1) << (cfg_shift - SHIFT_W'(1)));
      req_r = ($signed({a_prod[PW-1], a_prod}) + rnd) >>> cfg_shift;
   end

   always_comb begin
      zp_w = $signed({{(RW-8){cfg_zero_point[7]}}, cfg_zero_point});
      q_w  = b_r + zp_w;
      if (cfg_relu && (q_w < zp_w))
         q_w = zp_w;
      sat_q = q_w[7:0];
      if (q_w > SAT_HI)
         sat_q = 8'h7f;
      else if (q_w < SAT_LO)
         sat_q = 8'h80;
   end

   always_comb begin
      c_close        = c_valid && (c_last || (cnt == CNT_W'(LANES - 1)));
      out_free       = !o_valid || MO_AXIS_TREADY;
      freeze         = c_close && !out_free;
      advance        = !freeze;
      SD_AXIS_TREADY = rdy_en && !freeze;
      accept         = SD_AXIS_TVALID && SD_AXIS_TREADY;
      merged_data    = pack_data | ({{(DW-8){1'b0}}, c_q} << {cnt, 3'b000});
      merged_keep    = pack_keep | (LANES'(1) << cnt);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rdy_en    <= 1'b0;
         a_valid   <= 1'b0;
         a_last    <= 1'b0;
         a_prod    <= '0;
         b_valid   <= 1'b0;
         b_last    <= 1'b0;
         b_r       <= '0;
         c_valid   <= 1'b0;
         c_last    <= 1'b0;
         c_q       <= '0;
         cnt       <= '0;
         pack_data <= '0;
         pack_keep <= '0;
         o_valid   <= 1'b0;
         o_last    <= 1'b0;
         o_data    <= '0;
         o_keep    <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (advance) begin
            a_valid <= accept;
            a_prod  <= mul_p;
            a_last  <= SD_AXIS_TLAST;
            b_valid <= a_valid;
            b_r     <= req_r;
            b_last  <= a_last;
            c_valid <= b_valid;
            c_q     <= sat_q;
            c_last  <= b_last;
            if (c_valid) begin
               if (c_close) begin
                  pack_data <= '0;
                  pack_keep <= '0;
                  cnt       <= '0;
               end else begin
                  pack_data <= merged_data;
                  pack_keep <= merged_keep;
                  cnt       <= cnt + CNT_W'(1);
               end
            end
         end
         // A closing result only advances when the output register is free.
         if (advance && c_close) begin
            o_valid <= 1'b1;
            o_data  <= merged_data;
            o_keep  <= merged_keep;
            o_last  <= c_last;
         end else if (o_valid && MO_AXIS_TREADY) begin
            o_valid <= 1'b0;
         end
      end
   end

   assign MO_AXIS_TDATA  = o_data;
   assign MO_AXIS_TKEEP  = o_keep;
   assign MO_AXIS_TVALID = o_valid;
   assign MO_AXIS_TLAST  = o_last;

endmodule

// File: tb/tb_mac_requant_pack.sv
// Directed bench for mac_requant_pack: hand-computed beats in an expected queue,
// checked by a negedge monitor, including backpressure and mid-stream reset.
module tb_mac_requant_pack;

   logic        aclk;
   logic        aresetn;
   logic [31:0] sd_tdata;
   logic        sd_tvalid;
   logic        sd_tlast;
   logic        sd_tready;
   logic [31:0] mo_tdata;
   logic [3:0]  mo_tkeep;
   logic        mo_tvalid;
   logic        mo_tlast;
   logic        mo_tready;
   logic [15:0] cfg_scale;
   logic [4:0]  cfg_shift;
   logic [7:0]  cfg_zero_point;
   logic        cfg_relu;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [36:0] exp_q[$];
   logic stall_phase = 1'b0;
   logic saw_drop    = 1'b0;

   mac_requant_pack dut (
      .ACLK           (aclk),
      .ARESETN        (aresetn),
      .SD_AXIS_TDATA  (sd_tdata),
      .SD_AXIS_TVALID (sd_tvalid),
      .SD_AXIS_TLAST  (sd_tlast),
      .SD_AXIS_TREADY (sd_tready),
      .MO_AXIS_TDATA  (mo_tdata),
      .MO_AXIS_TKEEP  (mo_tkeep),
      .MO_AXIS_TVALID (mo_tvalid),
      .MO_AXIS_TLAST  (mo_tlast),
      .MO_AXIS_TREADY (mo_tready),
      .cfg_scale      (cfg_scale),
      .cfg_shift      (cfg_shift),
      .cfg_zero_point (cfg_zero_point),
      .cfg_relu       (cfg_relu)
   );

   // clock / reset
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total_cnt++;
      if (obs === expv)
         pass_cnt++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   // driver tasks
   task automatic send(input logic [31:0] acc, input logic last);
      logic done;
      done      = 1'b0;
      sd_tdata  = acc;
      sd_tlast  = last;
      sd_tvalid = 1'b1;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge aclk);
         if (sd_tready) begin
            @(posedge aclk);
            #1;
            done = 1'b1;
         end
      end
      if (!done)
         check("send_timeout", {63'd0, sd_tready}, 64'd1);
   endtask

   task automatic idle();
      sd_tvalid = 1'b0;
      sd_tlast  = 1'b0;
      sd_tdata  = '0;
   endtask

   task automatic set_cfg(input logic [15:0] sc, input logic [4:0] sh,
                          input logic [7:0] zp, input logic relu);
      cfg_scale      = sc;
      cfg_shift      = sh;
      cfg_zero_point = zp;
      cfg_relu       = relu;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 500 && exp_q.size() != 0; k++)
         @(posedge aclk);
      check("drain", 64'(exp_q.size()), 64'd0);
      repeat (6) @(posedge aclk);
      #1;
   endtask

   // scoreboard: every valid cycle must present the head of the expected queue
   always @(negedge aclk) begin
      if (aresetn && mo_tvalid) begin
         if (exp_q.size() == 0) begin
            check("spurious_beat", {63'd0, mo_tvalid}, 64'd0);
         end else begin
            check("beat", {27'd0, mo_tlast, mo_tkeep, mo_tdata}, {27'd0, exp_q[0]});
            if (mo_tready)
               void'(exp_q.pop_front());
         end
      end
      if (aresetn && stall_phase && !sd_tready)
         saw_drop = 1'b1;
   end

   initial begin
      aresetn   = 1'b0;
      mo_tready = 1'b1;
      idle();
      set_cfg(16'd1, 5'd0, 8'd0, 1'b0);

      // reset state
      repeat (2) @(negedge aclk);
      check("rst_sd_tready", {63'd0, sd_tready}, 64'd0);
      check("rst_mo_tvalid", {63'd0, mo_tvalid}, 64'd0);
      check("rst_mo_tdata",  {32'd0, mo_tdata},  64'd0);
      check("rst_mo_tkeep",  {60'd0, mo_tkeep},  64'd0);
      check("rst_mo_tlast",  {63'd0, mo_tlast},  64'd0);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check("rel_sd_tready", {63'd0, sd_tready}, 64'd1);
      @(posedge aclk);
      #1;

      // saturation, single-lane tile, latency
      exp_q.push_back({1'b1, 4'b0001, 32'h0000_007f});
      send(32'd2455, 1'b1);
      idle();
      repeat (2) begin
         @(posedge aclk);
         @(negedge aclk);
         check("lat_early", {63'd0, mo_tvalid}, 64'd0);
      end
      @(posedge aclk);
      @(negedge aclk);
      check("lat_n3", {63'd0, mo_tvalid}, 64'd1);
      wait_drain();

      // scale/shift rounding, two-lane tile
      set_cfg(16'd13, 5'd8, 8'd0, 1'b0);
      exp_q.push_back({1'b1, 4'b0011, 32'h0000_d07d});
      send(32'd2455, 1'b0);
      send(-32'sd946, 1'b1);
      idle();
      wait_drain();

      // full beats, two tiles
      set_cfg(16'd1, 5'd0, 8'd0, 1'b0);
      exp_q.push_back({1'b1, 4'b1111, 32'h0403_0201});
      exp_q.push_back({1'b1, 4'b1111, 32'h0807_0605});
      for (int i = 1; i <= 8; i++)
         send(32'(i), (i == 4) || (i == 8));
      idle();
      wait_drain();

      // ReLU with zero point -128, beat closes on full lanes without TLAST
      set_cfg(16'd1, 5'd0, 8'h80, 1'b1);
      exp_q.push_back({1'b0, 4'b1111, 32'h4887_8080});
      send(-32'sd5, 1'b0);
      send(-32'sd300, 1'b0);
      send(32'd7, 1'b0);
      send(32'd200, 1'b0);
      idle();
      wait_drain();

      // backpressure: 12 back-to-back results
      set_cfg(16'd1, 5'd0, 8'd0, 1'b0);
      exp_q.push_back({1'b0, 4'b1111, 32'h0403_0201});
      exp_q.push_back({1'b0, 4'b1111, 32'h0807_0605});
      exp_q.push_back({1'b1, 4'b1111, 32'h0c0b_0a09});
      saw_drop = 1'b0;
      fork
         begin
            for (int i = 1; i <= 12; i++)
               send(32'(i), i == 12);
            idle();
         end
         begin
            mo_tready   = 1'b0;
            stall_phase = 1'b1;
            for (int k = 0; k < 100 && !mo_tvalid; k++)
               @(negedge aclk);
            repeat (10) @(posedge aclk);
            #1;
            mo_tready   = 1'b1;
            stall_phase = 1'b0;
         end
      join
      wait_drain();
      check("stall_tready_dropped", {63'd0, saw_drop}, 64'd1);

      // reset after two lanes written discards the partial beat
      send(32'd10, 1'b0);
      send(32'd20, 1'b0);
      idle();
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b0;
      @(negedge aclk);
      check("mid_rst_sd_tready", {63'd0, sd_tready}, 64'd0);
      check("mid_rst_mo_tvalid", {63'd0, mo_tvalid}, 64'd0);
      check("mid_rst_mo_tkeep",  {60'd0, mo_tkeep},  64'd0);
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check("mid_rel_sd_tready", {63'd0, sd_tready}, 64'd1);
      @(posedge aclk);
      #1;
      exp_q.push_back({1'b1, 4'b1111, 32'h0807_0605});
      for (int i = 5; i <= 8; i++)
         send(32'(i), i == 8);
      idle();
      wait_drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
